// File: rtl/ti_packet_parser.sv
// ti_packet_parser: NoC packet receiver that splits a flit stream into a header bundle and a payload stream
module ti_packet_parser #(
  parameter int FLIT_SIZE = 32,
  parameter int HEADER_SIZE = 13,
  parameter int SERVICE_IDX = 0,
  parameter logic [FLIT_SIZE-1:0] DELIVERY_SERVICE = 'h43
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             rx_valid_i,
  output logic                             rx_ready_o,
  input  logic [FLIT_SIZE-1:0]             rx_data_i,
  output logic                             hdr_valid_o,
  input  logic                             hdr_ready_i,
  output logic [HEADER_SIZE*FLIT_SIZE-1:0] hdr_o,
  output logic [FLIT_SIZE-1:0]             hdr_target_o,
  output logic [FLIT_SIZE-1:0]             service_o,
  output logic                             inner_valid_o,
  output logic [FLIT_SIZE-1:0]             inner_service_o,
  output logic [FLIT_SIZE-1:0]             payload_len_o,
  output logic                             pl_valid_o,
  input  logic                             pl_ready_i,
  output logic [FLIT_SIZE-1:0]             pl_data_o,
  output logic                             pl_last_o,
  output logic                             err_o
);
  localparam int CW = HEADER_SIZE > 1 ? $clog2(HEADER_SIZE) : 1;
  localparam int HW = HEADER_SIZE * FLIT_SIZE;
  typedef enum logic [2:0] {IDLE, SIZE, HEADER, INNER, HDR_OUT, PAYLOAD, DRAIN} state_e;
  state_e state_q, state_d;
  logic [FLIT_SIZE-1:0] target_q, target_d, rem_q, rem_d, inner_q, inner_d, svc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hdr_q, hdr_d;
  logic inner_valid_q, inner_valid_d, err_q, err_d, rx_fire;
  assign rx_ready_o = state_q == PAYLOAD ? pl_ready_i : state_q != HDR_OUT;
  assign rx_fire = rx_valid_i && rx_ready_o;
  assign hdr_valid_o = state_q == HDR_OUT;
  assign hdr_o = hdr_q;
  assign hdr_target_o = target_q;
  assign service_o = hdr_q[SERVICE_IDX*FLIT_SIZE +: FLIT_SIZE];
  assign inner_valid_o = inner_valid_q;
  assign inner_service_o = inner_q;
  assign payload_len_o = rem_q;
  assign pl_valid_o = state_q == PAYLOAD && rx_valid_i;
  assign pl_data_o = state_q == PAYLOAD ? rx_data_i : '0;
  assign pl_last_o = state_q == PAYLOAD && rem_q == 1;
  assign err_o = err_q;
  // next-state: walks target, size, header words, optional inner word, then hands off or drains
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    rem_d = rem_q;
    inner_d = inner_q;
    inner_valid_d = inner_valid_q;
    cnt_d = cnt_q;
    hdr_d = hdr_q;
    svc_d = '0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (rx_fire) begin
        target_d = rx_data_i;
        state_d = SIZE;
      end
      SIZE: if (rx_fire) begin
        if (rx_data_i < FLIT_SIZE'(HEADER_SIZE)) begin
          err_d = 1'b1;
          rem_d = rx_data_i;
          state_d = rx_data_i == '0 ? IDLE : DRAIN;
        end else begin
          rem_d = rx_data_i - FLIT_SIZE'(HEADER_SIZE);
          cnt_d = '0;
          hdr_d = '0;
          inner_d = '0;
          inner_valid_d = 1'b0;
          state_d = HEADER;
        end
      end
      HEADER: if (rx_fire) begin
        for (int k = 0; k < HEADER_SIZE; k++)
          if (cnt_q == CW'(k)) hdr_d[k*FLIT_SIZE +: FLIT_SIZE] = rx_data_i;
        svc_d = hdr_d[SERVICE_IDX*FLIT_SIZE +: FLIT_SIZE];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(HEADER_SIZE - 1))
          state_d = (svc_d == DELIVERY_SERVICE && rem_q != '0) ? INNER : HDR_OUT;
      end
      INNER: if (rx_fire) begin
        inner_d = rx_data_i;
        inner_valid_d = 1'b1;
        rem_d = rem_q - 1'b1;
        state_d = HDR_OUT;
      end
      HDR_OUT: if (hdr_ready_i) state_d = rem_q != '0 ? PAYLOAD : IDLE;
      PAYLOAD, DRAIN: if (rx_fire) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == 1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset drops any packet in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      target_q <= '0;
      rem_q <= '0;
      inner_q <= '0;
      inner_valid_q <= 1'b0;
      cnt_q <= '0;
      hdr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      rem_q <= rem_d;
      inner_q <= inner_d;
      inner_valid_q <= inner_valid_d;
      cnt_q <= cnt_d;
      hdr_q <= hdr_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ti_packet_parser.sv
// tb_ti_packet_parser: randomized packet traffic checked against a queue-based packet model
module tb_ti_packet_parser;
  localparam int FS = 32;
  localparam int HS = 13;
  localparam int SI = 0;
  localparam logic [FS-1:0] DS = 32'h43;
  localparam int HW = HS * FS;
  typedef struct { logic [FS-1:0] d; bit bad; } flit_t;
  typedef struct { logic [FS-1:0] tgt; logic [HW-1:0] hdr; logic iv; logic [FS-1:0] inner; logic [FS-1:0] len; } hdr_t;
  typedef struct { logic [FS-1:0] d; logic last; } pl_t;
  logic clk_i = 1'b0, rst_ni, rx_valid_i, rx_ready_o, hdr_valid_o, hdr_ready_i;
  logic inner_valid_o, pl_valid_o, pl_ready_i, pl_last_o, err_o;
  logic [FS-1:0] rx_data_i, hdr_target_o, service_o, inner_service_o, payload_len_o, pl_data_o;
  logic [HW-1:0] hdr_o;
  flit_t tx_q[$];
  hdr_t hq[$];
  pl_t pq[$];
  logic [FS-1:0] pbuf[$];
  int n_chk = 0, n_fail = 0;
  int v_pct = 100, h_pct = 100, p_pct = 100, hdr_hold = 0;
  bit pl_alt = 0;
  ti_packet_parser #(.FLIT_SIZE(FS), .HEADER_SIZE(HS), .SERVICE_IDX(SI), .DELIVERY_SERVICE(DS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
    .hdr_valid_o(hdr_valid_o), .hdr_ready_i(hdr_ready_i), .hdr_o(hdr_o), .hdr_target_o(hdr_target_o),
    .service_o(service_o), .inner_valid_o(inner_valid_o), .inner_service_o(inner_service_o),
    .payload_len_o(payload_len_o), .pl_valid_o(pl_valid_o), .pl_ready_i(pl_ready_i), .pl_data_o(pl_data_o),
    .pl_last_o(pl_last_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [FS-1:0] d, input bit bad);
    flit_t f;
    f.d = d;
    f.bad = bad;
    tx_q.push_back(f);
  endtask
  task automatic send_pkt(input logic [FS-1:0] tgt, input logic [FS-1:0] svc);
    hdr_t h;
    pl_t p;
    int n;
    n = pbuf.size();
    h.hdr = '0;
    for (int k = 0; k < HS; k++) h.hdr[k*FS +: FS] = (k == SI) ? svc : $urandom;
    push(tgt, 0);
    push(FS'(HS + n), 0);
    for (int k = 0; k < HS; k++) push(h.hdr[k*FS +: FS], 0);
    foreach (pbuf[i]) push(pbuf[i], 0);
    h.tgt = tgt;
    h.iv = svc == DS && n > 0;
    h.inner = h.iv ? pbuf[0] : '0;
    h.len = FS'(n - int'(h.iv));
    hq.push_back(h);
    for (int i = int'(h.iv); i < n; i++) begin
      p.d = pbuf[i];
      p.last = i == n - 1;
      pq.push_back(p);
    end
    pbuf.delete();
  endtask
  task automatic send_bad(input logic [FS-1:0] tgt, input int s);
    push(tgt, 0);
    push(FS'(s), 1);
    for (int i = 0; i < s; i++) push($urandom, 0);
  endtask
  task automatic check_reset();
    check("rst_rx_ready", rx_ready_o, 1);
    check("rst_hdr_valid", hdr_valid_o, 0);
    check("rst_hdr", hdr_o, 0);
    check("rst_target", hdr_target_o, 0);
    check("rst_service", service_o, 0);
    check("rst_inner_v", inner_valid_o, 0);
    check("rst_inner", inner_service_o, 0);
    check("rst_len", payload_len_o, 0);
    check("rst_pl_valid", pl_valid_o, 0);
    check("rst_pl_data", pl_data_o, 0);
    check("rst_pl_last", pl_last_o, 0);
    check("rst_err", err_o, 0);
  endtask
  task automatic run(input int max_cyc, input int stop_pl);
    int cyc = 0, plx = 0, hw = 0;
    bit prev_bad = 0, prev_idle = 0;
    while ((tx_q.size() > 0 || hq.size() > 0 || pq.size() > 0) && cyc < max_cyc && !(stop_pl > 0 && plx >= stop_pl)) begin
      @(negedge clk_i);
      hw = hdr_valid_o ? hw + 1 : 0;
      rx_valid_i = tx_q.size() > 0 && $urandom_range(99) < v_pct;
      rx_data_i = tx_q.size() > 0 ? tx_q[0].d : $urandom;
      hdr_ready_i = hw > hdr_hold && $urandom_range(99) < h_pct;
      pl_ready_i = pl_alt ? ~pl_ready_i : $urandom_range(99) < p_pct;
      #1;
      check("err", err_o, prev_bad);
      if (prev_idle) check("b2b_rx_ready", rx_ready_o, 1);
      prev_bad = 0;
      prev_idle = 0;
      if (hdr_valid_o) begin
        check("hdr_rx_ready", rx_ready_o, 0);
        check("hdr_pl_valid", pl_valid_o, 0);
        if (hq.size() == 0) check("hdr_unexpected", hdr_valid_o, 0);
        else begin
          check("hdr_o", hdr_o, hq[0].hdr);
          check("target", hdr_target_o, hq[0].tgt);
          check("service", service_o, hq[0].hdr[SI*FS +: FS]);
          check("inner_valid", inner_valid_o, hq[0].iv);
          check("inner_service", inner_service_o, hq[0].inner);
          check("payload_len", payload_len_o, hq[0].len);
          if (hdr_ready_i) begin
            prev_idle = hq[0].len == 0;
            hq.pop_front();
          end
        end
      end
      if (pl_valid_o && pl_ready_i) begin
        if (pq.size() == 0) check("pl_unexpected", pl_valid_o, 0);
        else begin
          check("pl_data", pl_data_o, pq[0].d);
          check("pl_last", pl_last_o, pq[0].last);
          prev_idle = pq[0].last;
          pq.pop_front();
          plx++;
        end
      end
      if (rx_valid_i && rx_ready_o) begin
        prev_bad = tx_q[0].bad;
        tx_q.pop_front();
      end
      cyc++;
    end
    if (cyc >= max_cyc) check("timeout_pending", tx_q.size() + hq.size() + pq.size(), 0);
  endtask
  initial begin
    int n;
    rst_ni = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i = '0;
    hdr_ready_i = 1'b0;
    pl_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset();
    rst_ni = 1'b1;
    pbuf = '{32'hA, 32'hB};
    send_pkt(32'h0102, 32'h42);
    pbuf = '{32'h05, 32'hDEAD};
    send_pkt(32'h0203, 32'h43);
    send_pkt(32'h0304, 32'h40);
    send_pkt(32'h0405, 32'h42);
    send_bad(32'h0506, 4);
    pbuf = '{32'h11, 32'h22, 32'h33};
    send_pkt(32'h0607, 32'h42);
    run(2000, 0);
    hdr_hold = 5;
    pl_alt = 1;
    pbuf = '{32'h101, 32'h102, 32'h103, 32'h104};
    send_pkt(32'h0708, 32'h42);
    run(2000, 0);
    pl_alt = 0;
    v_pct = 70;
    h_pct = 60;
    p_pct = 60;
    for (int p = 0; p < 40; p++) begin
      hdr_hold = $urandom_range(2);
      if ($urandom_range(7) == 0) send_bad($urandom, $urandom_range(HS - 1));
      n = $urandom_range(6);
      for (int i = 0; i < n; i++) pbuf.push_back($urandom);
      send_pkt($urandom, $urandom_range(2) == 0 ? FS'($urandom) : FS'(32'h42 + $urandom_range(1)));
    end
    run(20000, 0);
    v_pct = 100;
    h_pct = 100;
    p_pct = 100;
    hdr_hold = 0;
    for (int i = 0; i < 6; i++) pbuf.push_back($urandom);
    send_pkt(32'h0809, 32'h42);
    run(500, 2);
    rst_ni = 1'b0;
    rx_valid_i = 1'b0;
    #1;
    check_reset();
    tx_q.delete();
    hq.delete();
    pq.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    pbuf = '{32'h77};
    send_pkt(32'h0A0B, 32'h42);
    run(500, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ti_packet_parser.md
# ti_packet_parser

Parametrised NoC packet receiver for the Task Injector datapath. It accepts a flit stream from the router-side port and captures the routing flit, the size flit and a HEADER_SIZE-word service header. For MESSAGE_DELIVERY packets it also extracts the inner service word. It presents the header as one parallel word and then streams the remaining payload flits with a last marker. Malformed packets are detected, drained and flagged, so downstream injector/mapper logic only ever sees well-formed headers.

## Interface
- FLIT_SIZE, 32, flit and header-word width in bits.
- HEADER_SIZE, 13, number of service-header words following the size flit.
- SERVICE_IDX, 0, index of the service word within the header.
- DELIVERY_SERVICE, 32'h43, service value that triggers inner-service extraction.
- clk_i  in  1  clock; all logic rising-edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- rx_valid_i  in  1  input flit valid.
- rx_ready_o  out  1  input flit accepted when rx_valid_i && rx_ready_o.
- rx_data_i  in  FLIT_SIZE  input flit.
- hdr_valid_o  out  1  header bundle valid.
- hdr_ready_i  in  1  header bundle consumed.
- hdr_o  out  HEADER_SIZE*FLIT_SIZE  header word k at bits [k*FLIT_SIZE +: FLIT_SIZE].
- hdr_target_o  out  FLIT_SIZE  routing (first) flit.
- service_o  out  FLIT_SIZE  header word SERVICE_IDX.
- inner_valid_o  out  1  inner_service_o is meaningful.
- inner_service_o  out  FLIT_SIZE  first payload flit of a delivery packet.
- payload_len_o  out  FLIT_SIZE  payload flits still to be streamed after the header handshake.
- pl_valid_o  out  1  payload flit valid.
- pl_ready_i  in  1  payload flit accepted.
- pl_data_o  out  FLIT_SIZE  payload flit.
- pl_last_o  out  1  final payload flit of the packet.
- err_o  out  1  one-cycle pulse: malformed packet.

## Operation
- States:
  - IDLE: the accepted flit is latched as target, then go to SIZE.
  - SIZE: the accepted flit is S, the count of flits after the size flit.
    - S < HEADER_SIZE: pulse err_o; go to DRAIN with remaining = S, or straight to IDLE if S = 0.
    - Otherwise: remaining = S − HEADER_SIZE; go to HEADER.
  - HEADER: accept HEADER_SIZE flits into hdr_o words 0..HEADER_SIZE−1 in order. After the last one:
    - go to INNER if service == DELIVERY_SERVICE and remaining ≥ 1;
    - otherwise go to HDR_OUT, with inner_valid_o = 0 and inner_service_o = 0.
  - INNER: accept one flit into inner_service_o, set inner_valid_o = 1, decrement remaining, go to HDR_OUT.
  - HDR_OUT: hdr_valid_o = 1; all header outputs stable. On hdr_ready_i, go to PAYLOAD if remaining > 0, else IDLE.
  - PAYLOAD: combinational pass-through.
    - pl_valid_o = rx_valid_i; rx_ready_o = pl_ready_i; pl_data_o = rx_data_i.
    - pl_last_o = (remaining == 1).
    - Each transfer decrements remaining; a transfer with remaining == 1 returns to IDLE.
  - DRAIN: accept and discard flits, decrementing remaining; return to IDLE when it reaches 0.
- rx_ready_o:
  - 1 in IDLE, SIZE, HEADER, INNER and DRAIN;
  - 0 in HDR_OUT;
  - equal to pl_ready_i in PAYLOAD.
- pl_valid_o is 0 outside PAYLOAD.
- payload_len_o equals remaining; it is valid in HDR_OUT and decrements in PAYLOAD.
- Counters are FLIT_SIZE bits with unsigned arithmetic; S is taken as the full flit value.
- The header word counter is $clog2(HEADER_SIZE) bits wide (minimum 1).
- Header registers and inner_valid_o are cleared on entry to HEADER. They hold their values after HDR_OUT until the next packet's HEADER state.

## Timing
- Reset: state = IDLE and every output = 0, except rx_ready_o = 1.
- Reset mid-packet discards the packet immediately. The first flit accepted after release is treated as a target flit.
- Header latency: hdr_valid_o rises in the cycle after the last header flit (or the inner flit) is accepted.
- First payload flit: can transfer in the cycle after the hdr_valid_o && hdr_ready_i handshake.
- Back-to-back: after the final payload transfer, or after the header handshake with no payload, IDLE accepts a new target flit the next cycle.
- Throughput: one flit per cycle in every accepting state.
- Stalls: no flit is lost or duplicated under any rx_valid_i, hdr_ready_i or pl_ready_i stall pattern.
- err_o is asserted exactly in the cycle after the bad size flit is accepted.

## Test plan
- Plain packet, HEADER_SIZE = 13: target 0x0102, size 15, service 0x42, payload 0xA, 0xB.
  - hdr_target_o = 0x0102, service_o = 0x42, payload_len_o = 2, inner_valid_o = 0.
  - Then 0xA with last = 0, then 0xB with last = 1, then IDLE.
- Delivery packet: size 15, service 0x43, payload 0x05, 0xDEAD.
  - inner_valid_o = 1, inner_service_o = 0x05, payload_len_o = 1.
  - One payload flit 0xDEAD with last = 1.
- Header-only packet: size 13, service 0x40.
  - Header handshake, no pl_valid_o.
  - Next packet's target is accepted the cycle after hdr_ready_i.
- Malformed packet: size 4, then 4 junk flits, then a good packet.
  - One err_o pulse; junk consumed with no hdr_valid_o; the good packet parses correctly.
- Backpressure:
  - hdr_ready_i held low 5 cycles: rx_ready_o = 0 and hdr_o stable throughout.
  - pl_ready_i alternating 1/0 on a 4-flit payload: exact order, no loss or duplication, last only on flit 4.
- Reset asserted during PAYLOAD:
  - All outputs return to reset values.
  - After release, the next flit is captured as hdr_target_o of a new packet.
